warp_reg_scoreboard: RTL

- Per-warp, per-register pending-write scoreboard between the warp scheduler and the execution units (LSU, ALU/tensor pipe).
- Generalises thread-level busy tracking to NUM_WARPS x NUM_REGS destination-register tracking.
- Supports NUM_CLR_PORTS independent completion channels, a per-warp outstanding-op counter with full back-pressure, and a warp flush.
- The scheduler issues only when issue_ready is high. Units return completions on the clear ports.

---
 rtl/sb_pkg.sv | 27 ++
 rtl/sb_warp_entry.sv | 57 +++++
 rtl/warp_reg_scoreboard.sv | 106 ++++++++++
 3 files changed

// File: rtl/sb_pkg.sv
// Shared width helpers and default sizing for the warp register scoreboard.
package sb_pkg;

  localparam int NUM_WARPS_DEF     = 4;
  localparam int NUM_REGS_DEF      = 16;
  localparam int NUM_CLR_PORTS_DEF = 2;
  localparam int MAX_PENDING_DEF   = 4;
  localparam int ZERO_REG_EN_DEF   = 1;

  // At least one bit, so single-entry configurations still elaborate.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int ww_of(input int num_warps);
    return idx_width(num_warps);
  endfunction

  function automatic int rw_of(input int num_regs);
    return idx_width(num_regs);
  endfunction

  function automatic int cw_of(input int max_pending);
    return idx_width(max_pending + 1);
  endfunction

endpackage

// File: rtl/sb_warp_entry.sv
// One warp's pending-register vector and outstanding-write counter.
module sb_warp_entry
  import sb_pkg::*;
#(
  parameter int NUM_REGS    = NUM_REGS_DEF,
  parameter int MAX_PENDING = MAX_PENDING_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REGS-1:0] set_oh,
  input  logic [NUM_REGS-1:0] clr_oh,
  input  logic                clr_dup,
  input  logic                flush,
  output logic [NUM_REGS-1:0] pending,
  output logic                full,
  output logic                idle,
  output logic                clr_err
);

  localparam int CW = cw_of(MAX_PENDING);

  logic [CW-1:0]       count;
  logic [NUM_REGS-1:0] clr_eff;
  int                  n_clr;
  int                  count_sum;

  always_comb begin
    clr_eff = clr_oh & pending;
    n_clr   = 0;
    for (int r = 0; r < NUM_REGS; r++) begin
      n_clr = n_clr + (clr_eff[r] ? 1 : 0);
    end
    count_sum = int'(count) + ((|set_oh) ? 1 : 0) - n_clr;
  end

  // A flush discards same-cycle clears, so they cannot be reported as bad.
  assign clr_err = !flush && (clr_dup || (|(clr_oh & ~pending)));

  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
      count   <= '0;
    end else if (flush) begin
      pending <= '0;
      count   <= '0;
    end else begin
      pending <= (pending & ~clr_oh) | set_oh;
      count   <= CW'(count_sum);
      assert (n_clr <= int'(count));
      assert (count_sum <= MAX_PENDING);
    end
  end

  assign full = (count == CW'(MAX_PENDING));
  assign idle = (count == '0);

endmodule

// File: rtl/warp_reg_scoreboard.sv
// Per-warp destination-register scoreboard: clear-port decode, hazard check
// against registered state, and sticky clear-error reporting.
module warp_reg_scoreboard
  import sb_pkg::*;
#(
  parameter int NUM_WARPS     = NUM_WARPS_DEF,
  parameter int NUM_REGS      = NUM_REGS_DEF,
  parameter int NUM_CLR_PORTS = NUM_CLR_PORTS_DEF,
  parameter int MAX_PENDING   = MAX_PENDING_DEF,
  parameter int ZERO_REG_EN   = ZERO_REG_EN_DEF,
  localparam int WW = ww_of(NUM_WARPS),
  localparam int RW = rw_of(NUM_REGS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          issue_valid,
  input  logic [WW-1:0]                 issue_warp,
  input  logic [RW-1:0]                 issue_rs1,
  input  logic [RW-1:0]                 issue_rs2,
  input  logic [RW-1:0]                 issue_rd,
  input  logic                          issue_rd_we,
  output logic                          issue_ready,
  input  logic [NUM_CLR_PORTS-1:0]      clr_valid,
  input  logic [NUM_CLR_PORTS*WW-1:0]   clr_warp,
  input  logic [NUM_CLR_PORTS*RW-1:0]   clr_rd,
  input  logic                          flush_valid,
  input  logic [WW-1:0]                 flush_warp,
  output logic [NUM_WARPS*NUM_REGS-1:0] pending_mask,
  output logic [NUM_WARPS-1:0]          warp_full,
  output logic [NUM_WARPS-1:0]          warp_idle,
  output logic                          err_clear
);

  logic                zero_en;
  logic [NUM_REGS-1:0] pend    [NUM_WARPS];
  logic [NUM_REGS-1:0] set_oh  [NUM_WARPS];
  logic [NUM_REGS-1:0] clr_oh  [NUM_WARPS];
  logic [NUM_WARPS-1:0] clr_dup;
  logic [NUM_WARPS-1:0] flush_oh;
  logic [NUM_WARPS-1:0] clr_err;
  logic [NUM_REGS-1:0] sel;
  logic                raw, waw, rd_write, accept;

  assign zero_en = (ZERO_REG_EN != 0);

  // Hazards look only at registered state: no clear-to-issue bypass.
  always_comb begin
    sel      = pend[issue_warp];
    raw      = (sel[issue_rs1] && !(zero_en && issue_rs1 == '0)) ||
               (sel[issue_rs2] && !(zero_en && issue_rs2 == '0));
    waw      = issue_rd_we && sel[issue_rd] && !(zero_en && issue_rd == '0);
    rd_write = issue_rd_we && !(zero_en && issue_rd == '0);
  end

  assign issue_ready = !raw && !waw && !warp_full[issue_warp] &&
                       !(flush_valid && flush_warp == issue_warp);
  assign accept      = issue_valid && issue_ready;

  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      set_oh[w]   = '0;
      clr_oh[w]   = '0;
      clr_dup[w]  = 1'b0;
      flush_oh[w] = flush_valid && (flush_warp == WW'(w));
      if (accept && rd_write && issue_warp == WW'(w)) begin
        set_oh[w][issue_rd] = 1'b1;
      end
      for (int p = 0; p < NUM_CLR_PORTS; p++) begin
        if (clr_valid[p] && clr_warp[p*WW +: WW] == WW'(w)) begin
          if (clr_oh[w][clr_rd[p*RW +: RW]]) begin
            clr_dup[w] = 1'b1;
          end
          clr_oh[w][clr_rd[p*RW +: RW]] = 1'b1;
        end
      end
    end
  end

  for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
    sb_warp_entry #(
      .NUM_REGS    (NUM_REGS),
      .MAX_PENDING (MAX_PENDING)
    ) u_entry (
      .clk     (clk),
      .reset   (reset),
      .set_oh  (set_oh[w]),
      .clr_oh  (clr_oh[w]),
      .clr_dup (clr_dup[w]),
      .flush   (flush_oh[w]),
      .pending (pend[w]),
      .full    (warp_full[w]),
      .idle    (warp_idle[w]),
      .clr_err (clr_err[w])
    );
    assign pending_mask[w*NUM_REGS +: NUM_REGS] = pend[w];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_clear <= 1'b0;
    end else if (|clr_err) begin
      err_clear <= 1'b1;
    end
  end

endmodule
